// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp scan sequencer: FSM states, scan modes, lamp count.
package lamp_pkg;

  localparam int unsigned LAMP_N = 8;
  localparam int unsigned IDX_W  = $clog2(LAMP_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP     = 2'b00;
  localparam mode_t MODE_DOWN   = 2'b01;
  localparam mode_t MODE_PP     = 2'b10;
  localparam mode_t MODE_UP_ALT = 2'b11;

endpackage

// File: rtl/lamp_dwell_cnt.sv
// Dwell counter: clears on load, counts while enabled, pulses tc_c on the last cycle of a dwell.
module lamp_dwell_cnt #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  assign tc_c = en && (cnt == limit - W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/lamp_scan_seq.sv
// Lamp scan sequencer driving a 3-to-8 decoder (select lines plus G/G2A/G2B enables).
// Define LAMP_SCAN_PINGPONG_EN to enable the ping-pong scan mode (mode 10).
module lamp_scan_seq
  import lamp_pkg::*;
#(
  parameter int unsigned        DWELL_W   = 24,
  parameter logic [DWELL_W-1:0] DWELL_DEF = DWELL_W'(5_000_000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel_c,
  output logic               sel_b,
  output logic               sel_a,
  output logic               g,
  output logic               g2a,
  output logic               g2b,
  output logic               busy,
  output logic               wrap
);

  state_t             state, state_d;
  logic               load_c, en_c, tc_c;
  logic [IDX_W-1:0]   idx, idx_step_c;
  logic               wrap_step_c;
  logic [DWELL_W-1:0] dwell_q;
  mode_t              mode_q, mode_eff_c;
`ifdef LAMP_SCAN_PINGPONG_EN
  logic               dir_q, dir_step_c;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Stop beats pause beats start; the counter advances only on edges that land in RUN.
  always_comb begin
    state_d = state;
    load_c  = 1'b0;
    en_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          load_c  = 1'b1;
        end
      end
      RUN: begin
        if (stop)       state_d = IDLE;
        else if (pause) state_d = HOLD;
        else            en_c    = 1'b1;
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
          en_c    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Modes without hardware support collapse to up.
  always_comb begin
    mode_eff_c = MODE_UP;
    if (mode == MODE_DOWN) mode_eff_c = MODE_DOWN;
`ifdef LAMP_SCAN_PINGPONG_EN
    else if (mode == MODE_PP) mode_eff_c = MODE_PP;
`endif
  end

  always_comb begin
    idx_step_c  = idx + IDX_W'(1);
    wrap_step_c = (idx == IDX_W'(LAMP_N - 1));
`ifdef LAMP_SCAN_PINGPONG_EN
    dir_step_c  = dir_q;
`endif
    if (mode_q == MODE_DOWN) begin
      idx_step_c  = idx - IDX_W'(1);
      wrap_step_c = (idx == '0);
    end
`ifdef LAMP_SCAN_PINGPONG_EN
    else if (mode_q == MODE_PP) begin
      // Turn around at each end so both endpoints are shown once per sweep.
      if (dir_q) begin
        idx_step_c  = idx - IDX_W'(1);
        wrap_step_c = (idx == IDX_W'(1));
        dir_step_c  = (idx != IDX_W'(1));
      end else begin
        idx_step_c  = idx + IDX_W'(1);
        wrap_step_c = 1'b0;
        dir_step_c  = (idx == IDX_W'(LAMP_N - 2));
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      dwell_q <= DWELL_DEF;
      mode_q  <= MODE_UP;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load_c) begin
        dwell_q <= (dwell == '0) ? DWELL_DEF : dwell;
        mode_q  <= mode_eff_c;
        idx     <= (mode_eff_c == MODE_DOWN) ? IDX_W'(LAMP_N - 1) : '0;
      end else if (tc_c) begin
        idx  <= idx_step_c;
        wrap <= wrap_step_c;
      end
    end
  end

`ifdef LAMP_SCAN_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      dir_q <= 1'b0;
    else if (load_c) dir_q <= 1'b0;
    else if (tc_c)   dir_q <= dir_step_c;
  end
`endif

  lamp_dwell_cnt #(
    .W(DWELL_W)
  ) u_dwell_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load_c),
    .en   (en_c),
    .limit(dwell_q),
    .tc_c (tc_c)
  );

  // Outputs decode straight from flops; no input reaches them combinationally.
  assign {sel_c, sel_b, sel_a} = idx;
  assign busy = (state != IDLE);
  assign g    = busy;
  assign g2a  = !busy;
  assign g2b  = !busy;

endmodule

// File: tb/tb_lamp_scan_seq.sv
// Directed bench for lamp_scan_seq: vector table plus hand sequences for sweeps, pause, reset and ping-pong.
module tb_lamp_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, pause, stop;
  logic [1:0]  mode;
  logic [23:0] dwell;
  logic        sel_c, sel_b, sel_a, g, g2a, g2b, busy, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        start;
    logic        pause;
    logic        stop;
    logic [1:0]  mode;
    logic [23:0] dwell;
    logic [2:0]  sel;
    logic        busy;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];

  lamp_scan_seq #(
    .DWELL_W  (24),
    .DWELL_DEF(24'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .stop (stop),
    .mode (mode),
    .dwell(dwell),
    .sel_c(sel_c),
    .sel_b(sel_b),
    .sel_a(sel_a),
    .g    (g),
    .g2a  (g2a),
    .g2b  (g2b),
    .busy (busy),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [2:0] esel, input logic ebusy,
                           input logic ewrap);
    logic [7:0] act, exp;
    act = {sel_c, sel_b, sel_a, g, g2a, g2b, busy, wrap};
    exp = {esel, ebusy, !ebusy, !ebusy, ebusy, ewrap};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sel,g,g2a,g2b,busy,wrap}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic pa, input logic sp, input logic [1:0] md,
                     input logic [23:0] dw, input logic [2:0] es, input logic eb,
                     input logic ew);
    vec_t v;
    v = '{st, pa, sp, md, dw, es, eb, ew};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic pa, input logic sp, input logic [1:0] md,
                       input logic [23:0] dw);
    start = st; pause = pa; stop = sp; mode = md; dwell = dw;
  endtask

  initial begin
    logic [2:0] exp_sel;

    // Down sweep at dwell 2 (mode/dwell changes mid-scan ignored), then stop priority in RUN and IDLE.
    add(1, 0, 0, 2'b01, 24'd2, 3'd7, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd7, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd6, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd6, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd5, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd5, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd4, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd4, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd3, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd3, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd2, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd2, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd1, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd1, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd0, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd0, 1, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd7, 1, 1);
    add(0, 0, 0, 2'b00, 24'd9, 3'd7, 1, 0);
    add(1, 1, 1, 2'b00, 24'd9, 3'd7, 0, 0);
    add(0, 0, 0, 2'b00, 24'd9, 3'd7, 0, 0);
    add(0, 1, 0, 2'b00, 24'd9, 3'd7, 0, 0);
    add(1, 0, 1, 2'b00, 24'd9, 3'd7, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 24'd0);
    step();
    step();
    check_out("reset", 3'd0, 0, 0);
    rst_n = 1'b1;
    step();
    check_out("idle_after_reset", 3'd0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].pause, vecs[i].stop, vecs[i].mode, vecs[i].dwell);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].busy, vecs[i].wrap);
    end

    // Up sweep, dwell 3.
    drive(1, 0, 0, 2'b00, 24'd3);
    step();
    drive(0, 0, 0, 2'b00, 24'd3);
    for (int i = 0; i < 24; i++) begin
      exp_sel = 3'(i / 3);
      check_out($sformatf("up_d3_%0d", i), exp_sel, 1, 0);
      step();
    end
    check_out("up_d3_wrap", 3'd0, 1, 1);
    step();
    check_out("up_d3_after_wrap", 3'd0, 1, 0);

    // Pause one cycle into sel=2 with dwell 4.
    drive(0, 0, 1, 2'b00, 24'd4);
    step();
    check_out("stop_before_pause", 3'd0, 0, 0);
    drive(1, 0, 0, 2'b00, 24'd4);
    step();
    drive(0, 0, 0, 2'b00, 24'd4);
    for (int i = 0; i < 8; i++) step();
    check_out("pause_sel2_first", 3'd2, 1, 0);
    step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_out($sformatf("pause_hold_%0d", i), 3'd2, 1, 0);
      step();
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_out($sformatf("pause_resume_%0d", i), 3'd2, 1, 0);
      step();
    end
    check_out("pause_advance", 3'd3, 1, 0);

    // Reset mid-scan at sel=5, then dwell 0 falls back to DWELL_DEF (4).
    for (int i = 0; i < 8; i++) step();
    check_out("pre_reset_sel5", 3'd5, 1, 0);
    rst_n = 1'b0;
    step();
    check_out("reset_mid_scan", 3'd0, 0, 0);
    start = 1'b1;
    step();
    check_out("reset_overrides_start", 3'd0, 0, 0);
    rst_n = 1'b1;
    drive(1, 0, 0, 2'b00, 24'd0);
    step();
    drive(0, 0, 0, 2'b00, 24'd0);
    for (int i = 0; i < 32; i++) begin
      exp_sel = 3'(i / 4);
      check_out($sformatf("dwell_def_%0d", i), exp_sel, 1, 0);
      step();
    end
    check_out("dwell_def_wrap", 3'd0, 1, 1);

    // Mode 10 at dwell 1: ping-pong when enabled, plain up otherwise.
    drive(0, 0, 1, 2'b00, 24'd1);
    step();
    drive(1, 0, 0, 2'b10, 24'd1);
    step();
    drive(0, 0, 0, 2'b10, 24'd1);
`ifdef LAMP_SCAN_PINGPONG_EN
    for (int i = 0; i < 14; i++) begin
      exp_sel = (i <= 7) ? 3'(i) : 3'(14 - i);
      check_out($sformatf("pp_%0d", i), exp_sel, 1, 0);
      step();
    end
`else
    for (int i = 0; i < 8; i++) begin
      exp_sel = 3'(i);
      check_out($sformatf("pp_as_up_%0d", i), exp_sel, 1, 0);
      step();
    end
`endif
    check_out("pp_wrap", 3'd0, 1, 1);
    step();
    check_out("pp_after_wrap", 3'd1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lamp_scan_seq.md
LAMP_SCAN_SEQ -- requirements
Module: lamp_scan_seq

Interface
REQ-001 Parameter DWELL_W, default 24: dwell counter width in bits.
REQ-002 Parameter DWELL_DEF, default 24'd5_000_000: dwell used when the dwell input is 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level; in IDLE, begins a scan.
REQ-006 pause  input  1  level; RUN->HOLD while high, HOLD->RUN when low.
REQ-007 stop  input  1  level; returns to IDLE from any state.
REQ-008 mode  input  2  00 up, 01 down, 10 ping-pong, 11 up; sampled only at start.
REQ-009 dwell  input  DWELL_W  cycles per lamp; sampled only at start.
REQ-010 sel_c, sel_b, sel_a  output  1 each  lamp index, MSB..LSB, driving decoder C/B/A.
REQ-011 g, g2a, g2b  output  1 each  decoder enables; active = g 1, g2a 0, g2b 0.
REQ-012 busy  output  1  high in RUN or HOLD.
REQ-013 wrap  output  1  one-cycle pulse at end of each full sweep.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-015 Priority SHALL be stop > pause > start when several are asserted in the same cycle.
REQ-016 IDLE->RUN SHALL occur on the edge where start=1 and stop=0.
REQ-017 At IDLE->RUN, dwell and mode SHALL be latched; a latched dwell of 0 SHALL be replaced by DWELL_DEF.
REQ-018 At IDLE->RUN, idx SHALL be 7 for mode down and 0 otherwise, and the dwell counter SHALL clear; outputs reflect this one cycle after start is sampled.
REQ-019 In RUN, the dwell counter SHALL increment each cycle; at count = latched dwell-1 it SHALL clear and idx SHALL advance.
REQ-020 Each lamp SHALL therefore be selected for exactly latched-dwell cycles.
REQ-021 idx advance in up mode SHALL wrap 7->0, asserting wrap on the cycle idx becomes 0.
REQ-022 idx advance in down mode SHALL wrap 0->7, asserting wrap on the cycle idx becomes 7.
REQ-023 Ping-pong SHALL sequence 0..7..0 with each endpoint shown once per turn (period 14 lamp slots); wrap SHALL assert when idx returns to 0.
REQ-024 In HOLD, idx and the dwell counter SHALL freeze and the outputs SHALL keep their values; resuming SHALL continue the remaining dwell.
REQ-025 Any state with stop=1 SHALL go to IDLE on the next edge.
REQ-026 In IDLE: g=0, g2a=1, g2b=1, busy=0, wrap=0, and idx retains its last value.
REQ-027 In RUN/HOLD: g=1, g2a=0, g2b=0, busy=1.
REQ-028 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-029 Changes to mode or dwell while busy SHALL be ignored.

Reset
REQ-030 With rst_n=0 at an edge: state IDLE, idx=0, dwell counter 0, latched dwell DWELL_DEF, latched mode up, and outputs per REQ-026 with sel=000.
REQ-031 Reset mid-scan SHALL abort the scan with no wrap pulse; reset overrides all inputs.

Configuration
REQ-032 Macro LAMP_SCAN_PINGPONG_EN: when defined, mode 10 SHALL behave per REQ-023.
REQ-033 When LAMP_SCAN_PINGPONG_EN is undefined, mode 10 SHALL behave as up, and no direction register SHALL exist.

Structure
REQ-034 Shared package lamp_pkg SHALL hold the state enum (IDLE/RUN/HOLD), the mode encodings and the lamp count (8).
REQ-035 Sub-module lamp_dwell_cnt (load, enable, terminal-count pulse) SHALL implement the dwell counter; the FSM and idx logic stay in lamp_scan_seq.

Verification
REQ-036 Reset, then start with mode=00, dwell=3 -> sel sequence 0,0,0,1,1,1,…,7,7,7,0; wrap is high exactly on the first cycle sel=0 after 7.
REQ-037 mode=01, dwell=2 -> sel 7,7,6,6,…,0,0,7; wrap is high on the return to 7; g=1, g2a=0, g2b=0 throughout.
REQ-038 Assert pause after 1 of 4 dwell cycles on sel=2, for 10 cycles -> sel stays 2 for the 10 cycles plus 3 more after release, then advances to 3.
REQ-039 Assert start, pause and stop in the same cycle while RUN -> next cycle IDLE: g=0, g2a=1, g2b=1, busy=0.
REQ-040 With macro defined, mode=10, dwell=1 -> sel 0..7,6..1,0 with wrap at that 0; with macro undefined, the same stimulus -> 0..7,0.
REQ-041 Pull rst_n low mid-scan at sel=5 -> next edge sel=000, IDLE outputs, no wrap pulse; start with dwell=0 -> each lamp held DWELL_DEF cycles (test with DWELL_DEF overridden to 4).
